led_pattern_seq: RTL and testbench



---
 rtl/led_pattern_seq_pkg.sv | 26 ++
 rtl/led_pattern_seq_if.sv | 35 +++
 rtl/led_pattern_seq_prescaler.sv | 40 ++++
 rtl/led_pattern_seq.sv | 121 ++++++++++++
 tb/tb_led_pattern_seq.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/led_pattern_seq_pkg.sv
// Shared mode/direction types and the step-period helper
// for the LED pattern sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_BIN    = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_ROTATE = 2'd2,
    MODE_GRAY   = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } bdir_e;

  function automatic int unsigned period(
    input int unsigned base,
    input int unsigned spd
  );
    int unsigned p;
    p = (spd > 31) ? 0 : (base >> spd);
    return (p == 0) ? 1 : p;
  endfunction

endpackage

// File: rtl/led_pattern_seq_if.sv
// Switch-side controls and LED-side outputs of the
// pattern sequencer (optional DIR under LED_SEQ_DIR_EN).
interface led_pattern_seq_if #(
  parameter int WIDTH = 8,
  parameter int SPD_W = 2
);
  logic [SPD_W-1:0] SPEED;
  logic [1:0]       MODE;
  logic             HOLD;
`ifdef LED_SEQ_DIR_EN
  logic             DIR;
`endif
  logic [WIDTH-1:0] OUT_BUS;
  logic             STEP;

`ifdef LED_SEQ_DIR_EN
  modport master (
    output SPEED, MODE, HOLD, DIR,
    input  OUT_BUS, STEP
  );
  modport slave (
    input  SPEED, MODE, HOLD, DIR,
    output OUT_BUS, STEP
  );
`else
  modport master (
    output SPEED, MODE, HOLD,
    input  OUT_BUS, STEP
  );
  modport slave (
    input  SPEED, MODE, HOLD,
    output OUT_BUS, STEP
  );
`endif
endinterface

// File: rtl/led_pattern_seq_prescaler.sv
// Prescaler: turns CLOCK into step ticks with period
// max(1, DIV_BASE >> SPEED); HOLD freezes, clr restarts.
module tick_prescaler
  import led_seq_pkg::*;
#(
  parameter int DIV_BASE = 6000000,
  parameter int SPD_W    = 2
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [SPD_W-1:0] SPEED,
  input  logic             HOLD,
  input  logic             clr,
  output logic             tick
);

  localparam int CW = $clog2(DIV_BASE + 1);

  logic [CW-1:0] pc;
  logic [CW-1:0] last;

  // >= rather than == so a faster SPEED catches up at once
  assign last = CW'(period(DIV_BASE, 32'(SPEED)) - 1);
  assign tick = !HOLD && (pc >= last);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      pc <= '0;
    end else if (clr) begin
      pc <= '0;
    end else if (HOLD) begin
      pc <= pc;
    end else if (tick) begin
      pc <= '0;
    end else begin
      pc <= pc + CW'(1);
    end
  end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer top: prescaler plus pattern engine.
// Define LED_SEQ_DIR_EN to add the DIR reverse input.
module led_pattern_seq
  import led_seq_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SPD_W    = 2,
  parameter int DIV_BASE = 6000000
) (
  input  logic         CLOCK,
  input  logic         RESET,
  led_pattern_seq_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] out_q, out_n;
  logic [WIDTH-1:0] cnt_q, cnt_n;
  bdir_e            dir_q, dir_n;
  mode_e            mode_q, mode_in;
  logic             step_q, step_n;
  logic             tick, mode_chg, rev;

  assign mode_in  = mode_e'(bus.MODE);
  assign mode_chg = (mode_in != mode_q);

`ifdef LED_SEQ_DIR_EN
  assign rev = bus.DIR;
`else
  assign rev = 1'b0;
`endif

  tick_prescaler #(
    .DIV_BASE (DIV_BASE),
    .SPD_W    (SPD_W)
  ) u_presc (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .SPEED (bus.SPEED),
    .HOLD  (bus.HOLD),
    .clr   (mode_chg),
    .tick  (tick)
  );

  always_comb begin
    out_n  = out_q;
    cnt_n  = cnt_q;
    dir_n  = dir_q;
    step_n = 1'b0;
    // a mode change reseeds and wins over a coincident tick
    if (mode_chg) begin
      cnt_n = '0;
      dir_n = DIR_LEFT;
      unique case (mode_in)
        MODE_BOUNCE,
        MODE_ROTATE: out_n = ONE;
        MODE_BIN,
        MODE_GRAY:   out_n = '0;
      endcase
    end else if (tick) begin
      step_n = 1'b1;
      unique case (mode_q)
        MODE_BIN: begin
          out_n = rev ? out_q - ONE : out_q + ONE;
        end
        MODE_GRAY: begin
          cnt_n = rev ? cnt_q - ONE : cnt_q + ONE;
          out_n = cnt_n ^ (cnt_n >> 1);
        end
        MODE_ROTATE: begin
          out_n = rev ?
            (out_q >> 1) | (out_q << (WIDTH - 1)) :
            (out_q << 1) | (out_q >> (WIDTH - 1));
        end
        MODE_BOUNCE: begin
          unique case (1'b1)
            (WIDTH == 1): begin
              out_n = ONE;
            end
            (WIDTH > 1) && (dir_q == DIR_LEFT): begin
              if (out_q[WIDTH-1]) begin
                dir_n = DIR_RIGHT;
                out_n = out_q >> 1;
              end else begin
                out_n = out_q << 1;
              end
            end
            default: begin
              if (out_q[0]) begin
                dir_n = DIR_LEFT;
                out_n = out_q << 1;
              end else begin
                out_n = out_q >> 1;
              end
            end
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      out_q  <= '0;
      cnt_q  <= '0;
      dir_q  <= DIR_LEFT;
      mode_q <= MODE_BIN;
      step_q <= 1'b0;
    end else begin
      out_q  <= out_n;
      cnt_q  <= cnt_n;
      dir_q  <= dir_n;
      mode_q <= mode_in;
      step_q <= step_n;
    end
  end

  assign bus.OUT_BUS = out_q;
  assign bus.STEP    = step_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq, WIDTH=8 DIV_BASE=16.
// Expected values are hand-derived step sequences and periods.
module tb_led_pattern_seq;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  int   checks = 0;
  int   failures = 0;

  led_pattern_seq_if #(.WIDTH(8), .SPD_W(2)) bus ();

  led_pattern_seq #(
    .WIDTH    (8),
    .SPD_W    (2),
    .DIV_BASE (16)
  ) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check_eq(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic wait_step(output int n);
    n = 0;
    do begin
      @(posedge CLOCK);
      #1;
      n++;
    end while (!bus.STEP && n < 100);
  endtask

  task automatic do_reset();
    @(negedge CLOCK);
    RESET = 1'b1;
    @(negedge CLOCK);
    RESET = 1'b0;
  endtask

  logic [7:0] bnc [15] = '{
    8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
    8'h40, 8'h80, 8'h40, 8'h20, 8'h10,
    8'h08, 8'h04, 8'h02, 8'h01, 8'h02
  };
  logic [7:0] gry [6] = '{
    8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05
  };

  initial begin
    int n;
    int tot;
    int bad;
    bus.SPEED = 2'd0;
    bus.MODE  = 2'd0;
    bus.HOLD  = 1'b0;
`ifdef LED_SEQ_DIR_EN
    bus.DIR   = 1'b0;
`endif
    #2;
    check_eq("rst_out", 32'(bus.OUT_BUS), 32'h0);
    check_eq("rst_step", 32'(bus.STEP), 32'h0);

    // BIN at SPEED=0
    do_reset();
    wait_step(n);
    check_eq("bin_first_lat", n, 16);
    check_eq("bin_first_out", 32'(bus.OUT_BUS), 32'h01);
    wait_step(n);
    check_eq("bin_period", n, 16);
    check_eq("bin_second_out", 32'(bus.OUT_BUS), 32'h02);
    tot = 0;
    for (int i = 0; i < 253; i++) begin
      wait_step(n);
      tot += n;
    end
    check_eq("bin_ff_out", 32'(bus.OUT_BUS), 32'hFF);
    check_eq("bin_run_len", tot, 253 * 16);
    wait_step(n);
    check_eq("bin_wrap_out", 32'(bus.OUT_BUS), 32'h00);
    check_eq("bin_wrap_step", 32'(bus.STEP), 32'h1);

    // BOUNCE from reset
    bus.MODE = 2'd1;
    do_reset();
    clk_n(1);
    check_eq("bnc_seed", 32'(bus.OUT_BUS), 32'h01);
    check_eq("bnc_seed_step", 32'(bus.STEP), 32'h0);
    for (int i = 0; i < 15; i++) begin
      wait_step(n);
      check_eq($sformatf("bnc_%0d", i),
               32'(bus.OUT_BUS), 32'(bnc[i]));
    end

    // ROTATE, then GRAY on a coincident tick
    bus.MODE = 2'd2;
    do_reset();
    clk_n(1);
    check_eq("rot_seed", 32'(bus.OUT_BUS), 32'h01);
    for (int i = 1; i <= 8; i++) begin
      wait_step(n);
      check_eq($sformatf("rot_%0d", i), 32'(bus.OUT_BUS),
               32'(8'h01 << (i % 8)));
    end
    for (int i = 0; i < 3; i++) wait_step(n);
    check_eq("rot_mid", 32'(bus.OUT_BUS), 32'h08);
    clk_n(15);
    bus.MODE = 2'd3;
    clk_n(1);
    check_eq("gry_seed", 32'(bus.OUT_BUS), 32'h00);
    check_eq("gry_seed_step", 32'(bus.STEP), 32'h0);
    wait_step(n);
    check_eq("gry_restart_lat", n, 16);
    check_eq("gry_0", 32'(bus.OUT_BUS), 32'(gry[0]));
    for (int i = 1; i < 6; i++) begin
      wait_step(n);
      check_eq($sformatf("gry_%0d", i),
               32'(bus.OUT_BUS), 32'(gry[i]));
    end

    // SPEED changes
    bus.MODE  = 2'd0;
    bus.SPEED = 2'd2;
    do_reset();
    wait_step(n);
    check_eq("spd2_lat", n, 4);
    wait_step(n);
    check_eq("spd2_period", n, 4);
    check_eq("spd2_out", 32'(bus.OUT_BUS), 32'h02);
    bus.SPEED = 2'd0;
    wait_step(n);
    check_eq("spd0_period", n, 16);
    clk_n(10);
    bus.SPEED = 2'd2;
    wait_step(n);
    check_eq("spd_catchup", n, 1);
    check_eq("spd_catchup_out", 32'(bus.OUT_BUS), 32'h04);
    wait_step(n);
    check_eq("spd_after", n, 4);

    // HOLD mid-count
    bus.SPEED = 2'd0;
    wait_step(n);
    check_eq("hold_pre_out", 32'(bus.OUT_BUS), 32'h06);
    clk_n(6);
    bus.HOLD = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      clk_n(1);
      if (bus.STEP || bus.OUT_BUS != 8'h06) bad++;
    end
    check_eq("hold_frozen", bad, 0);
    bus.HOLD = 1'b0;
    wait_step(n);
    check_eq("hold_resume", n, 10);
    check_eq("hold_resume_out", 32'(bus.OUT_BUS), 32'h07);

    // asynchronous reset between edges
    bus.MODE = 2'd1;
    do_reset();
    for (int i = 0; i < 6; i++) wait_step(n);
    check_eq("arst_pre", 32'(bus.OUT_BUS), 32'h40);
    #2;
    RESET = 1'b1;
    #1;
    check_eq("arst_out", 32'(bus.OUT_BUS), 32'h0);
    check_eq("arst_step", 32'(bus.STEP), 32'h0);
    @(negedge CLOCK);
    RESET = 1'b0;

`ifdef LED_SEQ_DIR_EN
    bus.MODE = 2'd0;
    bus.DIR  = 1'b1;
    do_reset();
    wait_step(n);
    check_eq("dir_ff", 32'(bus.OUT_BUS), 32'hFF);
    wait_step(n);
    check_eq("dir_fe", 32'(bus.OUT_BUS), 32'hFE);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
